// File: rtl/apes_pkg.sv
// apes_pkg: shared state encodings, default channel count and counter
// widths for the detector pulse-input conditioner.
`timescale 1ns/1ps
package apes_pkg;

   // Per-channel conditioner states; chan_busy is simply (state != IDLE).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HIGH = 2'd2,
      DEAD = 2'd3
   } chan_state_t;

   localparam int NCH_DEFAULT = 50;
   localparam int WCNT_W      = 4;    // width-qualification counter
   localparam int DCNT_W      = 8;    // dead-time counter
   localparam int HCNT_W      = 13;   // continuous-high counter for stuck detection

endpackage

// File: rtl/inpulse_chan.sv
// inpulse_chan: one detector channel. Synchronises the raw discriminator
// output into clk50, qualifies a minimum pulse width, emits one count strobe
// per pulse, holds off for a dead time and flags pile-up during it.
// Optional stuck-high detector built only when STUCK_DETECT_EN is defined;
// otherwise stuck is tied low.
`timescale 1ns/1ps
module inpulse_chan
   import apes_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int MIN_WIDTH    = 3,
   parameter int DEAD_TIME    = 10
`ifdef STUCK_DETECT_EN
   ,parameter int STUCK_CYCLES = 5000
`endif
) (
   input  logic clk50,
   input  logic rst,
   input  logic enable,
   input  logic raw,
   output logic pulse_stb,
   output logic pileup_stb,
   output logic busy,
   output logic stuck
);

   localparam logic [WCNT_W-1:0] WCNT_MIN  = WCNT_W'(MIN_WIDTH);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
   localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(DEAD_TIME);
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s_d_reg;
   logic [SYNC_STAGES:0]   prime_reg;
   logic                   s;
   logic                   rise;
   logic                   edge_ok;

   chan_state_t            state_reg;
   logic [WCNT_W-1:0]      wcnt_reg;
   logic [DCNT_W-1:0]      dcnt_reg;
   logic                   pulse_stb_reg;
   logic                   pileup_stb_reg;
   logic                   busy_reg;

   assign s    = sync_reg[SYNC_STAGES-1];
   assign rise = s & ~s_d_reg;
   // Reset clears the synchroniser, so an input held high through reset would
   // look like a fresh rise once the chain refills. Edges only count once the
   // chain and s_d hold genuine input samples again.
   assign edge_ok = prime_reg[SYNC_STAGES];

   // Synchroniser chain, edge-detect delay and post-reset priming shifter.
   always_ff @(posedge clk50) begin
      if (rst) begin
         sync_reg  <= '0;
         s_d_reg   <= 1'b0;
         prime_reg <= '0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw};
         s_d_reg   <= s;
         prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Channel FSM with registered strobes and busy flag.
   always_ff @(posedge clk50) begin
      if (rst || !enable) begin
         state_reg      <= IDLE;
         wcnt_reg       <= '0;
         dcnt_reg       <= '0;
         pulse_stb_reg  <= 1'b0;
         pileup_stb_reg <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         pulse_stb_reg  <= 1'b0;
         pileup_stb_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Only a rise seen in the synced domain arms the channel, so a
               // level still high from before cannot be counted twice.
               if (rise && edge_ok) begin
                  wcnt_reg <= WCNT_ONE;
                  busy_reg <= 1'b1;
                  if (WCNT_MIN == WCNT_ONE) begin
                     pulse_stb_reg <= 1'b1;
                     state_reg     <= HIGH;
                  end else begin
                     state_reg <= QUAL;
                  end
               end
            end
            QUAL: begin
               if (wcnt_reg == WCNT_MIN) begin
                  // Width qualified: strobe once, then track the falling edge.
                  pulse_stb_reg <= 1'b1;
                  wcnt_reg      <= '0;
                  if (s) begin
                     state_reg <= HIGH;
                  end else if (DCNT_INIT == '0) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     state_reg <= DEAD;
                     dcnt_reg  <= DCNT_INIT;
                  end
               end else if (!s) begin
                  // Too short: dropped silently.
                  state_reg <= IDLE;
                  wcnt_reg  <= '0;
                  busy_reg  <= 1'b0;
               end else begin
                  wcnt_reg <= wcnt_reg + 1'b1;
               end
            end
            HIGH: begin
               if (!s) begin
                  if (DCNT_INIT == '0) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     state_reg <= DEAD;
                     dcnt_reg  <= DCNT_INIT;
                  end
               end
            end
            DEAD: begin
               // A new rise here is pile-up: flagged, not counted, and the
               // hold-off is not extended.
               if (rise) begin
                  pileup_stb_reg <= 1'b1;
               end
               if (dcnt_reg <= DCNT_ONE) begin
                  state_reg <= IDLE;
                  dcnt_reg  <= '0;
                  busy_reg  <= 1'b0;
               end else begin
                  dcnt_reg <= dcnt_reg - 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_stb  = pulse_stb_reg;
   assign pileup_stb = pileup_stb_reg;
   assign busy       = busy_reg;

`ifdef STUCK_DETECT_EN
   localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(STUCK_CYCLES);

   logic [HCNT_W-1:0] hcnt_reg;
   logic              stuck_reg;

   // Continuous-high counter; the stuck flag latches until reset and never
   // blocks counting.
   always_ff @(posedge clk50) begin
      if (rst) begin
         hcnt_reg  <= '0;
         stuck_reg <= 1'b0;
      end else begin
         if (!s) begin
            hcnt_reg <= '0;
         end else if (hcnt_reg != HCNT_MAX) begin
            hcnt_reg <= hcnt_reg + 1'b1;
         end
         if (s && (hcnt_reg == HCNT_MAX - 1'b1)) begin
            stuck_reg <= 1'b1;
         end
      end
   end

   assign stuck = stuck_reg;
`else
   assign stuck = 1'b0;
`endif

endmodule

// File: rtl/inpulse_conditioner.sv
// inpulse_conditioner: front-end conditioner for the detector pulse inputs,
// feeding pulse_counters. Pure wrapper: NCH independent inpulse_chan copies.
// Define STUCK_DETECT_EN to build the per-channel stuck-high detectors.
`timescale 1ns/1ps
module inpulse_conditioner
   import apes_pkg::*;
#(
   parameter int NCH          = NCH_DEFAULT,
   parameter int SYNC_STAGES  = 2,
   parameter int MIN_WIDTH    = 3,
   parameter int DEAD_TIME    = 10
`ifdef STUCK_DETECT_EN
   ,parameter int STUCK_CYCLES = 5000
`endif
) (
   input  logic           clk50,
   input  logic           rst,
   input  logic           enable,
   input  logic [NCH-1:0] Inpulse_raw,
   output logic [NCH-1:0] pulse_stb,
   output logic [NCH-1:0] pileup_stb,
   output logic [NCH-1:0] chan_busy,
   output logic [NCH-1:0] stuck
);

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         inpulse_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .MIN_WIDTH    (MIN_WIDTH),
            .DEAD_TIME    (DEAD_TIME)
`ifdef STUCK_DETECT_EN
            ,.STUCK_CYCLES (STUCK_CYCLES)
`endif
         ) u_chan (
            .clk50      (clk50),
            .rst        (rst),
            .enable     (enable),
            .raw        (Inpulse_raw[gi]),
            .pulse_stb  (pulse_stb[gi]),
            .pileup_stb (pileup_stb[gi]),
            .busy       (chan_busy[gi]),
            .stuck      (stuck[gi])
         );
      end
   endgenerate

endmodule
